// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags with head-pointer checkpoints
// for single-cycle branch-mispredict recovery.
module phys_reg_free_list #(
  parameter int unsigned FREE_LIST_DEPTH    = 64,
  parameter int unsigned NUM_ARCH_REGS      = 32,
  parameter int unsigned PHYS_REG_WIDTH     = 6,
  parameter int unsigned CHECKPOINT_COLUMNS = 4
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  dequeue_valid,
  output logic [PHYS_REG_WIDTH-1:0]             dequeue_phys_reg_tag,
  output logic                                  empty,
  input  logic                                  enqueue_valid,
  input  logic [PHYS_REG_WIDTH-1:0]             enqueue_phys_reg_tag,
  output logic                                  full,
  input  logic                                  revert_valid,
  input  logic [PHYS_REG_WIDTH-1:0]             revert_phys_reg_tag,
  input  logic                                  save_checkpoint_valid,
  output logic                                  save_checkpoint_success,
  output logic [$clog2(CHECKPOINT_COLUMNS)-1:0] save_checkpoint_column,
  input  logic                                  restore_checkpoint_valid,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] restore_checkpoint_column,
  output logic                                  restore_checkpoint_success,
  input  logic                                  clear_checkpoint_valid,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] clear_checkpoint_column
);

  localparam int unsigned IdxW = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PHYS_REG_WIDTH-1:0]   mem_q [FREE_LIST_DEPTH];
  logic [PHYS_REG_WIDTH-1:0]   mem_d [FREE_LIST_DEPTH];
  logic [PtrW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CHECKPOINT_COLUMNS-1:0] ckpt_valid_q, ckpt_valid_d;
  logic [PtrW-1:0]             ckpt_head_q [CHECKPOINT_COLUMNS];
  logic [PtrW-1:0]             ckpt_head_d [CHECKPOINT_COLUMNS];

  logic [PtrW-1:0] count;
  logic [PtrW-1:0] head_m1;
  logic            restore_fire;

  // Extra pointer MSB separates full from empty when the indices coincide.
  assign count   = tail_q - head_q;
  assign head_m1 = head_q - PtrW'(1);
  assign empty   = (count == '0);
  assign full    = (count == PtrW'(FREE_LIST_DEPTH));

  assign dequeue_phys_reg_tag       = mem_q[head_q[IdxW-1:0]];
  assign restore_fire               = restore_checkpoint_valid &
                                      ckpt_valid_q[restore_checkpoint_column];
  assign restore_checkpoint_success = restore_fire;

  // Lowest-index free column; scanning downward leaves the smallest one last.
  always_comb begin
    save_checkpoint_success = 1'b0;
    save_checkpoint_column  = '0;
    for (int c = int'(CHECKPOINT_COLUMNS) - 1; c >= 0; c--) begin
      if (!ckpt_valid_q[c]) begin
        save_checkpoint_success = 1'b1;
        save_checkpoint_column  = $clog2(CHECKPOINT_COLUMNS)'(c);
      end
    end
  end

  always_comb begin
    mem_d        = mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    ckpt_valid_d = ckpt_valid_q;
    ckpt_head_d  = ckpt_head_q;

    // Commits are non-speculative, so enqueue proceeds even during a restore.
    if (enqueue_valid && !full) begin
      mem_d[tail_q[IdxW-1:0]] = enqueue_phys_reg_tag;
      tail_d                  = tail_q + PtrW'(1);
    end

    if (restore_fire) begin
      head_d = ckpt_head_q[restore_checkpoint_column];
    end else if (revert_valid) begin
      head_d                   = head_m1;
      mem_d[head_m1[IdxW-1:0]] = revert_phys_reg_tag;
    end else if (dequeue_valid && !empty) begin
      head_d = head_q + PtrW'(1);
    end

    // Clear first so a save into the same column takes precedence.
    if (clear_checkpoint_valid) ckpt_valid_d[clear_checkpoint_column] = 1'b0;
    if (save_checkpoint_valid && save_checkpoint_success && !restore_fire) begin
      ckpt_valid_d[save_checkpoint_column] = 1'b1;
      ckpt_head_d[save_checkpoint_column]  = head_q;
    end
    if (restore_fire) ckpt_valid_d[restore_checkpoint_column] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(FREE_LIST_DEPTH); i++) begin
        if (i < int'(FREE_LIST_DEPTH - NUM_ARCH_REGS)) begin
          mem_q[i] <= PHYS_REG_WIDTH'(int'(NUM_ARCH_REGS) + i);
        end else begin
          mem_q[i] <= '0;
        end
      end
      head_q       <= '0;
      tail_q       <= PtrW'(FREE_LIST_DEPTH - NUM_ARCH_REGS);
      ckpt_valid_q <= '0;
      for (int c = 0; c < int'(CHECKPOINT_COLUMNS); c++) ckpt_head_q[c] <= '0;
    end else begin
      mem_q        <= mem_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      ckpt_valid_q <= ckpt_valid_d;
      ckpt_head_q  <= ckpt_head_d;
    end
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular FIFO of free physical register tags for the out-of-order MIPS core.
- Rename/dispatch dequeues a destination tag per register-writing instruction.
- ROB commit enqueues the freed safe tag.
- ROB revert pushes speculated tags back at the head.
- The BRU checkpoint system saves and restores the head pointer across CHECKPOINT_COLUMNS columns for single-cycle mispredict recovery.

## Interface
- FREE_LIST_DEPTH, 64, entries in the FIFO (equals NUM_PHYS_REGS)
- NUM_ARCH_REGS, 32, tags 0..NUM_ARCH_REGS-1 are architecturally mapped at reset
- PHYS_REG_WIDTH, 6, tag width
- CHECKPOINT_COLUMNS, 4, checkpoint columns; column index width is log2 (2)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dequeue_valid  in  1  rename takes the head tag this cycle
- dequeue_phys_reg_tag  out  6  current head tag (combinational from array)
- empty  out  1  no free tags
- enqueue_valid  in  1  commit frees a tag
- enqueue_phys_reg_tag  in  6  freed tag
- full  out  1  count == FREE_LIST_DEPTH
- revert_valid  in  1  ROB revert returns a speculated tag
- revert_phys_reg_tag  in  6  tag returned to head
- save_checkpoint_valid  in  1  BRU dispatch requests a checkpoint
- save_checkpoint_success  out  1  a free column exists
- save_checkpoint_column  out  2  column allocated (lowest-index free column)
- restore_checkpoint_valid  in  1  mispredict restore request
- restore_checkpoint_column  in  2  column to restore
- restore_checkpoint_success  out  1  requested column is valid
- clear_checkpoint_valid  in  1  release a column (branch resolved or squashed)
- clear_checkpoint_column  in  2  column to release

## Operation
- Storage: array[FREE_LIST_DEPTH] of tags; head and tail pointers are 7 bits (extra MSB for wrap); count = tail - head (7-bit). empty = (count == 0); full = (count == 64).
- Reset: entry i = NUM_ARCH_REGS + i for i in 0..31; other entries = 0. head = 0; tail = 32; all checkpoint columns invalid with saved head = 0.
- Dequeue (dequeue_valid & ~empty): head += 1. Dequeue when empty is ignored; head is unchanged.
- Enqueue (enqueue_valid & ~full): array[tail[5:0]] <= tag; tail += 1. Enqueue when full is ignored; the bench flags it as an error.
- Revert (revert_valid): head -= 1; array[(head-1)[5:0]] <= revert tag. Revert wins over dequeue in the same cycle; that combination is illegal and the dequeue is dropped.
- Save: if a free column exists, set valid, record the current (pre-update) head, and output the lowest-index free column with success = 1. When no free column exists, success = 0 and no state changes.
- Restore (restore_checkpoint_valid & column valid): head <= saved head; that column is invalidated. Restore overrides dequeue, revert and save in the same cycle. Enqueue still applies, because commits are non-speculative. Restore of an invalid column: success = 0 and the request is ignored.
- Clear: column valid <= 0. When clear and save hit the same column in one cycle, save wins. Save and clear of different columns proceed independently.
- Younger columns are not auto-invalidated on restore; the BRU issues clears for them.

## Timing
- dequeue_phys_reg_tag, empty, full, save_checkpoint_success/column and restore_checkpoint_success are combinational from registered state and current inputs.
- All pointer, array and column updates take effect at the next rising CLK. A tag enqueued in cycle N is dequeueable at cycle N+1 at the earliest, and only once head reaches it.
- Simultaneous enqueue and dequeue: count is unchanged. With count == 0, dequeue is ignored even if an enqueue arrives the same cycle; there is no bypass.
- Wrap: pointers wrap modulo 128. Index uses bits [5:0]; full and empty are distinguished by the MSB.
- nRST asserted mid-operation: all state returns to reset values asynchronously. Outputs reflect reset state immediately: tag = 32, empty = 0, full = 0, save success = 1, save column = 0, restore success = 0.

## Test plan
- Reset, then 32 dequeues: tags 32..63 in order. After the last, empty = 1; a further dequeue leaves head unchanged.
- Enqueue 5, 6, 7 after draining: empty deasserts the cycle after the first enqueue; tags come out 5, 6, 7 in order. Fill to 64 entries -> full = 1, and a further enqueue is ignored.
- Save checkpoint with head = 3 -> column 0, success = 1. Dequeue 4 tags, then restore column 0 -> next cycle the tag equals the original entry 3 (35); column 0 is freed.
- Save 4 checkpoints -> columns 0..3. A fifth save -> success = 0. Clear column 2, then save -> column 2.
- Dequeue 40, 41, then revert 41, then revert 40 -> head returns; the next dequeue yields 40, then 41.
- Same-cycle restore + enqueue + dequeue: head = saved value, tail advances by 1, dequeue dropped. Same-cycle enqueue + dequeue at count = 1: count stays 1.
